// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: single-entry dispatch buffer routing decoded instructions to the RS or the LSB.
// Optional stall counter built only when DISPATCH_PERF_EN is defined.
`default_nettype none
`timescale 1ns/1ps

module dispatch_ctrl #(
  parameter int ROB_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [16:0]          dec_opcode,
  input  logic [4:0]           dec_rd,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [31:0]          dec_imm,
  input  logic [31:0]          dec_pc,
  input  logic                 rob_full,
  input  logic [ROB_IDX_W-1:0] rob_tag,
  output logic                 rob_alloc,
  input  logic                 rs_full,
  output logic                 rs_valid,
  input  logic                 lsb_full,
  output logic                 lsb_valid,
  output logic [16:0]          disp_opcode,
  output logic [4:0]           disp_rd,
  output logic [4:0]           disp_rs1,
  output logic [4:0]           disp_rs2,
  output logic [31:0]          disp_imm,
  output logic [31:0]          disp_pc,
  output logic [ROB_IDX_W-1:0] disp_tag,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [0:0] C_IDLE     = 1'b0;
  localparam logic [0:0] C_HOLD     = 1'b1;
  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;

  logic [0:0]  state_q, state_d;
  logic [16:0] opcode_q, opcode_d;
  logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d, pc_q, pc_d;

  logic w_hold, w_is_mem, w_tgt_full, w_fire, w_accept;

  assign w_hold     = (state_q == C_HOLD);
  assign w_is_mem   = (opcode_q[6:0] == C_OP_LOAD) || (opcode_q[6:0] == C_OP_STORE);
  // A held instruction only waits on the queue it is headed for.
  assign w_tgt_full = w_is_mem ? lsb_full : rs_full;
  assign w_fire     = rdy_in & ~flush_in & w_hold & ~rob_full & ~w_tgt_full;
  // rst_n_in gates the handshake so nothing is offered while reset is held.
  assign dec_ready  = rst_n_in & rdy_in & ~flush_in & (~w_hold | w_fire);
  assign w_accept   = dec_valid & dec_ready;

  assign rob_alloc  = w_fire;
  assign rs_valid   = w_fire & ~w_is_mem;
  assign lsb_valid  = w_fire & w_is_mem;

  assign disp_opcode = w_hold ? opcode_q : '0;
  assign disp_rd     = w_hold ? rd_q     : '0;
  assign disp_rs1    = w_hold ? rs1_q    : '0;
  assign disp_rs2    = w_hold ? rs2_q    : '0;
  assign disp_imm    = w_hold ? imm_q    : '0;
  assign disp_pc     = w_hold ? pc_q     : '0;
  assign disp_tag    = w_fire ? rob_tag  : '0;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = C_IDLE;
      end else if (w_accept) begin
        state_d  = C_HOLD;
        opcode_d = dec_opcode;
        rd_d     = dec_rd;
        rs1_d    = dec_rs1;
        rs2_d    = dec_rs2;
        imm_d    = dec_imm;
        pc_d     = dec_pc;
      end else if (w_fire) begin
        state_d = C_IDLE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= C_IDLE;
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic             w_stall_cyc;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign w_stall_cyc = rdy_in & ~flush_in & w_hold & ~w_fire;

  // Saturates at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall_cyc && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed self-checking bench for dispatch_ctrl.
`default_nettype none
`timescale 1ns/1ps

module tb_dispatch_ctrl;

  localparam int ROB_IDX_W = 4;
  localparam int CNT_W     = 32;
  localparam logic [16:0] OP_ADD = {3'b000, 7'b0, 7'b0110011};
  localparam logic [16:0] OP_SW  = {3'b010, 7'b0, 7'b0100011};
  localparam logic [16:0] OP_LW  = {3'b010, 7'b0, 7'b0000011};
`ifdef DISPATCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                 clk_in = 1'b0;
  logic                 rst_n_in, rdy_in, flush_in, dec_valid, dec_ready;
  logic [16:0]          dec_opcode, disp_opcode;
  logic [4:0]           dec_rd, dec_rs1, dec_rs2, disp_rd, disp_rs1, disp_rs2;
  logic [31:0]          dec_imm, dec_pc, disp_imm, disp_pc;
  logic                 rob_full, rob_alloc, rs_full, rs_valid, lsb_full, lsb_valid;
  logic [ROB_IDX_W-1:0] rob_tag, disp_tag;
  logic [CNT_W-1:0]     stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dispatch_ctrl #(.ROB_IDX_W(ROB_IDX_W), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm),
    .dec_pc(dec_pc), .rob_full(rob_full), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
    .rs_full(rs_full), .rs_valid(rs_valid), .lsb_full(lsb_full), .lsb_valid(lsb_valid),
    .disp_opcode(disp_opcode), .disp_rd(disp_rd), .disp_rs1(disp_rs1),
    .disp_rs2(disp_rs2), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_tag(disp_tag), .stall_cnt(stall_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  task automatic present(input logic v, input logic [16:0] op, input logic [4:0] rd,
                         input logic [31:0] pc);
    dec_valid  = v;
    dec_opcode = op;
    dec_rd     = rd;
    dec_rs1    = 5'd1;
    dec_rs2    = 5'd2;
    dec_imm    = 32'h0000_0010;
    dec_pc     = pc;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tag = '0;
    present(1'b0, '0, '0, '0);

    // Reset state
    sample();
    check("rst_dec_ready", dec_ready, 0);
    check("rst_rob_alloc", rob_alloc, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_disp_pc", disp_pc, 0);
    next_cycle();
    rst_n_in = 1'b1;

    // Single ALU op to the RS
    next_cycle();
    present(1'b1, OP_ADD, 5'd7, 32'h100);
    rob_tag = 4'd3;
    sample();
    check("s1_accept_ready", dec_ready, 1);
    check("s1_no_early_fire", rob_alloc, 0);
    next_cycle();
    present(1'b0, '0, '0, '0);
    sample();
    check("s1_rs_valid", rs_valid, 1);
    check("s1_rob_alloc", rob_alloc, 1);
    check("s1_disp_tag", disp_tag, 3);
    check("s1_lsb_valid", lsb_valid, 0);
    check("s1_disp_rd", disp_rd, 7);
    check("s1_disp_pc", disp_pc, 32'h100);
    next_cycle();
    sample();
    check("s1_single_pulse", rs_valid, 0);

    // Load blocked by LSB for 5 cycles; rs_full must not matter
    next_cycle();
    present(1'b1, OP_LW, 5'd9, 32'h200);
    lsb_full = 1'b1; rs_full = 1'b1;
    sample();
    check("s2_accept_ready", dec_ready, 1);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      present(1'b0, '0, '0, '0);
      lsb_full = (i < 5);
      sample();
      check($sformatf("s2_lsb_valid_%0d", i), lsb_valid, (i == 5));
      check($sformatf("s2_rs_valid_%0d", i), rs_valid, 0);
    end
    next_cycle();
    lsb_full = 1'b0; rs_full = 1'b0;
    sample();
    check("s2_stall_cnt", stall_cnt, PERF ? 5 : 0);
    check("s2_idle", lsb_valid, 0);

    // Back-to-back ADD, SW, ADD
    next_cycle();
    present(1'b1, OP_ADD, 5'd1, 32'h300);
    sample();
    check("s3_c0_ready", dec_ready, 1);
    next_cycle();
    present(1'b1, OP_SW, 5'd2, 32'h304);
    rob_tag = 4'd5;
    sample();
    check("s3_c1_rs_valid", rs_valid, 1);
    check("s3_c1_lsb_valid", lsb_valid, 0);
    check("s3_c1_ready", dec_ready, 1);
    check("s3_c1_tag", disp_tag, 5);
    next_cycle();
    present(1'b1, OP_ADD, 5'd3, 32'h308);
    rob_tag = 4'd6;
    sample();
    check("s3_c2_lsb_valid", lsb_valid, 1);
    check("s3_c2_rs_valid", rs_valid, 0);
    check("s3_c2_ready", dec_ready, 1);
    check("s3_c2_opcode", disp_opcode, OP_SW);
    check("s3_c2_pc", disp_pc, 32'h304);
    next_cycle();
    present(1'b0, '0, '0, '0);
    rob_tag = 4'd7;
    sample();
    check("s3_c3_rs_valid", rs_valid, 1);
    check("s3_c3_rd", disp_rd, 3);
    check("s3_c3_tag", disp_tag, 7);

    // Held under rob_full, then flushed
    next_cycle();
    present(1'b1, OP_ADD, 5'd4, 32'h400);
    rob_full = 1'b1;
    sample();
    check("s4_accept_ready", dec_ready, 1);
    next_cycle();
    present(1'b0, '0, '0, '0);
    sample();
    check("s4_hold_alloc", rob_alloc, 0);
    check("s4_hold_ready", dec_ready, 0);
    check("s4_hold_payload", disp_rd, 4);
    next_cycle();
    flush_in = 1'b1;
    sample();
    check("s4_flush_alloc", rob_alloc, 0);
    check("s4_flush_ready", dec_ready, 0);
    next_cycle();
    flush_in = 1'b0; rob_full = 1'b0;
    sample();
    check("s4_post_ready", dec_ready, 1);
    check("s4_post_rs_valid", rs_valid, 0);
    check("s4_post_disp_rd", disp_rd, 0);

    // rdy_in low for 3 cycles while held
    next_cycle();
    present(1'b1, OP_ADD, 5'd5, 32'h500);
    sample();
    check("s5_accept_ready", dec_ready, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      present(1'b0, '0, '0, '0);
      rdy_in = 1'b0;
      sample();
      check($sformatf("s5_frozen_alloc_%0d", i), rob_alloc, 0);
      check($sformatf("s5_frozen_ready_%0d", i), dec_ready, 0);
    end
    next_cycle();
    rdy_in = 1'b1;
    sample();
    check("s5_resume_rs_valid", rs_valid, 1);
    check("s5_resume_rd", disp_rd, 5);
    check("s5_stall_cnt", stall_cnt, PERF ? 6 : 0);

    // Asynchronous reset while holding a ready-to-fire instruction
    next_cycle();
    present(1'b1, OP_ADD, 5'd6, 32'h1000_0040);
    next_cycle();
    present(1'b0, '0, '0, '0);
    #2;
    check("s6_pre_rs_valid", rs_valid, 1);
    check("s6_pre_pc", disp_pc, 32'h1000_0040);
    rst_n_in = 1'b0;
    #1;
    check("s6_rst_rs_valid", rs_valid, 0);
    check("s6_rst_alloc", rob_alloc, 0);
    check("s6_rst_ready", dec_ready, 0);
    check("s6_rst_pc", disp_pc, 0);
    check("s6_rst_stall", stall_cnt, 0);
    next_cycle();
    #2;
    rst_n_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      check($sformatf("s6_post_rs_valid_%0d", i), rs_valid, 0);
      check($sformatf("s6_post_ready_%0d", i), dec_ready, 1);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
